// File: rtl/pipeline_interlock_controller.sv
// Purpose : central stall/flush sequencer for the five-stage core (PC, IF/ID, ID/EX, EX/MEM controls).
// Latency : control outputs are combinational in (state, inputs, rst); state/counters/flag update at the next edge.
// Backpressure: dmem_busy freezes the whole pipe; load-use stalls the front end only; branches squash IF/ID.
//
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   load_use_hazard_i       - load-use stall request from hazard detection
//   branch_taken_i          - taken branch/jump resolved in ID this cycle
//   dmem_busy_i             - MEM-stage access not complete this cycle
//   pc_write_o .. ex_mem_hold_o - pipeline register enables / squash controls
//   state_o                 - 0 RUN, 1 MEM_WAIT, 2 FLUSH
//   stall_count_o, flush_count_o - saturating performance counters
//   mem_timeout_o           - sticky: dmem_busy held TIMEOUT consecutive cycles
module pipeline_interlock_controller #(
    parameter int BRANCH_PENALTY = 1,
    parameter int TIMEOUT        = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_use_hazard_i,
    input  logic                 branch_taken_i,
    input  logic                 dmem_busy_i,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_bubble_o,
    output logic                 ex_mem_hold_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o,
    output logic                 mem_timeout_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    localparam int PEN_W  = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY + 1) : 1;
    localparam int BUSY_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [PEN_W-1:0]  PEN_INIT  = PEN_W'(BRANCH_PENALTY - 1);
    localparam logic [PEN_W-1:0]  PEN_ONE   = PEN_W'(1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT - 1);
    localparam logic [BUSY_W-1:0] BUSY_ONE  = BUSY_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic [PEN_W-1:0]      pen_q, pen_d;
    logic [BUSY_W-1:0]     busy_q, busy_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;

    // Pipeline controls and FSM next state, highest priority first:
    // reset, memory freeze, remaining branch penalty, new branch, load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        state_d      = state_q;
        pen_d        = pen_q;

        if (rst_i) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = ST_RUN;
            pen_d        = '0;
        end else if (dmem_busy_i) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            // A freeze in FLUSH keeps the remaining penalty intact.
            if (state_q != ST_FLUSH) begin
                state_d = ST_MEM_WAIT;
            end
        end else if (state_q == ST_FLUSH) begin
            // ID holds a squashed instruction, so branch/load-use are ignored.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pen_d        = pen_q - PEN_ONE;
            if (pen_q == PEN_ONE) begin
                state_d = ST_RUN;
            end
        end else begin
            // RUN and MEM_WAIT (once released) behave identically.
            state_d = ST_RUN;
            if (branch_taken_i) begin
                if_id_flush = 1'b1;
                if (BRANCH_PENALTY > 1) begin
                    state_d = ST_FLUSH;
                    pen_d   = PEN_INIT;
                end
            end else if (load_use_hazard_i) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Busy run length, sticky timeout and saturating performance counters.
    always_comb begin
        busy_d        = '0;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (dmem_busy_i) begin
            if (busy_q == BUSY_LAST) begin
                busy_d        = busy_q;
                mem_timeout_d = 1'b1;
            end else begin
                busy_d = busy_q + BUSY_ONE;
            end
        end

        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            pen_q         <= '0;
            busy_q        <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pen_q         <= pen_d;
            busy_q        <= busy_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign pc_write_o     = pc_write;
    assign if_id_write_o  = if_id_write;
    assign if_id_flush_o  = if_id_flush;
    assign id_ex_bubble_o = id_ex_bubble;
    assign ex_mem_hold_o  = ex_mem_hold;
    assign state_o        = state_q;
    assign stall_count_o  = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
    assign mem_timeout_o  = mem_timeout_q;

endmodule
